noc_inject_sequencer: RTL and testbench



---
 rtl/noc_inject_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_noc_inject_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_sequencer.sv
// noc_inject_sequencer
// Packet-injection engine for the NoC adder datapath. A run issues NUM_PKT
// packets; each packet is a burst of one-cycle start strobes (one per source
// channel), followed by a wait for the datapath completion flag, result
// capture/accumulation, and an optional idle gap before the next burst.
// The wait for completion is protected by an optional timeout.
module noc_inject_sequencer #(
    parameter int NUM_SRC = 2,
    parameter int TDATAW  = 32,
    parameter int CNTW    = 16,
    parameter int GAPW    = 8,
    parameter int TOW     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               EN,
    input  logic [CNTW-1:0]    NUM_PKT,
    input  logic [GAPW-1:0]    GAP,
    input  logic [TOW-1:0]     TIMEOUT,
    input  logic               DONE_I,
    input  logic [TDATAW-1:0]  DATA_I,
    output logic [NUM_SRC-1:0] START_O,
    output logic               BUSY,
    output logic               FINISHED,
    output logic               TIMED_OUT,
    output logic [CNTW-1:0]    PKT_CNT,
    output logic [TDATAW-1:0]  RESULT_O,
    output logic [TDATAW-1:0]  SUM_O
);

    // Index of the strobe currently being issued; at least one bit wide so a
    // single-channel build still has a legal vector.
    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_SRC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_FINISH    = 3'd4
    } state_e;

    state_e              state_q,     state_d;
    logic [IDXW-1:0]     idx_q,       idx_d;
    logic [TOW-1:0]      wait_q,      wait_d;
    logic [GAPW-1:0]     gap_cnt_q,   gap_cnt_d;

    // Run configuration, frozen at run start so mid-run input changes are inert.
    logic [CNTW-1:0]     num_pkt_q,   num_pkt_d;
    logic [GAPW-1:0]     gap_q,       gap_d;
    logic [TOW-1:0]      timeout_q,   timeout_d;

    // Result bookkeeping visible on the outputs.
    logic [CNTW-1:0]     pkt_cnt_q,   pkt_cnt_d;
    logic [TDATAW-1:0]   result_q,    result_d;
    logic [TDATAW-1:0]   sum_q,       sum_d;
    logic                timed_out_q, timed_out_d;

    // Packet count including the packet completing this cycle.
    logic [CNTW-1:0]     pkt_inc;
    assign pkt_inc = pkt_cnt_q + CNTW'(1);

    // Next-state and datapath update; an EN drop outranks everything else so
    // an aborted run never captures a late completion.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        gap_cnt_d   = gap_cnt_q;
        num_pkt_d   = num_pkt_q;
        gap_d       = gap_q;
        timeout_d   = timeout_q;
        pkt_cnt_d   = pkt_cnt_q;
        result_d    = result_q;
        sum_d       = sum_q;
        timed_out_d = timed_out_q;

        if ((state_q != S_IDLE) && !EN) begin
            // Abort: results of the partial run stay visible.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (EN) begin
                        num_pkt_d   = NUM_PKT;
                        gap_d       = GAP;
                        timeout_d   = TIMEOUT;
                        pkt_cnt_d   = '0;
                        result_d    = '0;
                        sum_d       = '0;
                        timed_out_d = 1'b0;
                        idx_d       = '0;
                        state_d     = (NUM_PKT == '0) ? S_FINISH : S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (idx_q == IDX_LAST) begin
                        wait_d  = '0;
                        state_d = S_WAIT_DONE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end

                S_WAIT_DONE: begin
                    if (DONE_I) begin
                        // Completion wins over a timeout landing on the same cycle.
                        result_d  = DATA_I;
                        sum_d     = sum_q + DATA_I;
                        pkt_cnt_d = pkt_inc;
                        if (pkt_inc == num_pkt_q) begin
                            state_d = S_FINISH;
                        end else if (gap_q == '0) begin
                            idx_d   = '0;
                            state_d = S_ISSUE;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end
                    end else if ((timeout_q != '0) && (wait_q == (timeout_q - TOW'(1)))) begin
                        timed_out_d = 1'b1;
                        state_d     = S_FINISH;
                    end else begin
                        // Free-running when the timeout is disabled; wrap is harmless.
                        wait_d = wait_q + TOW'(1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == (gap_q - GAPW'(1))) begin
                        idx_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAPW'(1);
                    end
                end

                S_FINISH: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and bookkeeping registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            gap_cnt_q   <= '0;
            num_pkt_q   <= '0;
            gap_q       <= '0;
            timeout_q   <= '0;
            pkt_cnt_q   <= '0;
            result_q    <= '0;
            sum_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            gap_cnt_q   <= gap_cnt_d;
            num_pkt_q   <= num_pkt_d;
            gap_q       <= gap_d;
            timeout_q   <= timeout_d;
            pkt_cnt_q   <= pkt_cnt_d;
            result_q    <= result_d;
            sum_q       <= sum_d;
            timed_out_q <= timed_out_d;
        end
    end

    // One-hot start strobes decoded from the registered state and index.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_start
            assign START_O[gi] = (state_q == S_ISSUE) && (idx_q == IDXW'(gi));
        end
    endgenerate

    // Moore status outputs.
    assign BUSY      = (state_q != S_IDLE);
    assign FINISHED  = (state_q == S_FINISH);
    assign TIMED_OUT = timed_out_q;
    assign PKT_CNT   = pkt_cnt_q;
    assign RESULT_O  = result_q;
    assign SUM_O     = sum_q;

endmodule

// File: tb/tb_noc_inject_sequencer.sv
// Directed testbench for noc_inject_sequencer (NUM_SRC=2, TDATAW=32).
// Inputs change and outputs are observed on the falling clock edge.
module tb_noc_inject_sequencer;

    logic        clk;
    logic        rst_n;
    logic        EN;
    logic [15:0] NUM_PKT;
    logic [7:0]  GAP;
    logic [15:0] TIMEOUT;
    logic        DONE_I;
    logic [31:0] DATA_I;
    logic [1:0]  START_O;
    logic        BUSY;
    logic        FINISHED;
    logic        TIMED_OUT;
    logic [15:0] PKT_CNT;
    logic [31:0] RESULT_O;
    logic [31:0] SUM_O;

    int checks = 0;
    int errors = 0;

    noc_inject_sequencer #(
        .NUM_SRC(2), .TDATAW(32), .CNTW(16), .GAPW(8), .TOW(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .NUM_PKT(NUM_PKT), .GAP(GAP),
        .TIMEOUT(TIMEOUT), .DONE_I(DONE_I), .DATA_I(DATA_I), .START_O(START_O),
        .BUSY(BUSY), .FINISHED(FINISHED), .TIMED_OUT(TIMED_OUT),
        .PKT_CNT(PKT_CNT), .RESULT_O(RESULT_O), .SUM_O(SUM_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        checks++; if (START_O !== 2'b00) begin errors++; $display("FAIL reset_start got %b exp 00", START_O); end
        checks++; if (FINISHED !== 1'b0) begin errors++; $display("FAIL reset_finished got %b exp 0", FINISHED); end
        checks++; if (TIMED_OUT !== 1'b0) begin errors++; $display("FAIL reset_timed_out got %b exp 0", TIMED_OUT); end
        checks++; if (PKT_CNT !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt got %0d exp 0", PKT_CNT); end
        checks++; if (RESULT_O !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", RESULT_O); end
        checks++; if (SUM_O !== 32'd0) begin errors++; $display("FAIL reset_sum got %h exp 0", SUM_O); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", BUSY); end
        $display("test_reset done");
    endtask

    task automatic test_normal();
        logic [31:0] dv [3];
        logic [31:0] exp_sum;
        dv = '{32'd5, 32'd7, 32'd9};
        exp_sum = 32'd0;
        NUM_PKT = 16'd3; GAP = 8'd0; TIMEOUT = 16'd0; EN = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            checks++; if (START_O !== 2'b01 || BUSY !== 1'b1) begin errors++; $display("FAIL normal_start0 p=%0d got %b/%b exp 01/1", p, START_O, BUSY); end
            tick();
            checks++; if (START_O !== 2'b10) begin errors++; $display("FAIL normal_start1 p=%0d got %b exp 10", p, START_O); end
            tick();
            checks++; if (START_O !== 2'b00) begin errors++; $display("FAIL normal_wait_start p=%0d got %b exp 00", p, START_O); end
            repeat (3) tick();
            DONE_I = 1'b1; DATA_I = dv[p];
            tick();
            DONE_I = 1'b0; DATA_I = 32'd0;
            exp_sum = exp_sum + dv[p];
            checks++; if (PKT_CNT !== 16'(p + 1)) begin errors++; $display("FAIL normal_pkt_cnt p=%0d got %0d exp %0d", p, PKT_CNT, p + 1); end
            checks++; if (RESULT_O !== dv[p]) begin errors++; $display("FAIL normal_result p=%0d got %0d exp %0d", p, RESULT_O, dv[p]); end
            checks++; if (SUM_O !== exp_sum) begin errors++; $display("FAIL normal_sum p=%0d got %0d exp %0d", p, SUM_O, exp_sum); end
        end
        checks++; if (FINISHED !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL normal_finished got %b/%b exp 1/1", FINISHED, BUSY); end
        checks++; if (TIMED_OUT !== 1'b0) begin errors++; $display("FAIL normal_timed_out got %b exp 0", TIMED_OUT); end
        EN = 1'b0;
        tick();
        checks++; if (FINISHED !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL normal_after got %b/%b exp 0/0", FINISHED, BUSY); end
        checks++; if (PKT_CNT !== 16'd3 || RESULT_O !== 32'd9 || SUM_O !== 32'd21) begin errors++; $display("FAIL normal_hold got %0d/%0d/%0d exp 3/9/21", PKT_CNT, RESULT_O, SUM_O); end
        $display("test_normal done");
    endtask

    task automatic test_gap();
        NUM_PKT = 16'd2; GAP = 8'd3; TIMEOUT = 16'd0; EN = 1'b1;
        tick(); tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'd1;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (START_O !== 2'b00 || PKT_CNT !== 16'd1) begin errors++; $display("FAIL gap_first got %b/%0d exp 00/1", START_O, PKT_CNT); end
        DONE_I = 1'b1; DATA_I = 32'd100;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (PKT_CNT !== 16'd1 || SUM_O !== 32'd1 || RESULT_O !== 32'd1) begin errors++; $display("FAIL gap_spurious got %0d/%0d/%0d exp 1/1/1", PKT_CNT, SUM_O, RESULT_O); end
        checks++; if (START_O !== 2'b00) begin errors++; $display("FAIL gap_mid2 got %b exp 00", START_O); end
        tick();
        checks++; if (START_O !== 2'b00) begin errors++; $display("FAIL gap_mid3 got %b exp 00", START_O); end
        tick();
        checks++; if (START_O !== 2'b01) begin errors++; $display("FAIL gap_restart got %b exp 01", START_O); end
        tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'd2;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (PKT_CNT !== 16'd2 || SUM_O !== 32'd3 || FINISHED !== 1'b1) begin errors++; $display("FAIL gap_end got %0d/%0d/%b exp 2/3/1", PKT_CNT, SUM_O, FINISHED); end
        EN = 1'b0;
        tick();
        $display("test_gap done");
    endtask

    task automatic test_sum_wrap();
        NUM_PKT = 16'd2; GAP = 8'd0; TIMEOUT = 16'd0; EN = 1'b1;
        tick(); tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'hFFFF_FFFF;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (SUM_O !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_first got %h exp ffffffff", SUM_O); end
        tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'd2;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (SUM_O !== 32'd1 || RESULT_O !== 32'd2 || PKT_CNT !== 16'd2) begin errors++; $display("FAIL wrap_sum got %h/%0d/%0d exp 1/2/2", SUM_O, RESULT_O, PKT_CNT); end
        checks++; if (FINISHED !== 1'b1) begin errors++; $display("FAIL wrap_finished got %b exp 1", FINISHED); end
        EN = 1'b0;
        tick();
        $display("test_sum_wrap done");
    endtask

    task automatic test_timeout();
        NUM_PKT = 16'd1; GAP = 8'd0; TIMEOUT = 16'd10; EN = 1'b1;
        tick(); tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (FINISHED !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL timeout_wait%0d got %b/%b exp 0/1", i, FINISHED, BUSY); end
        end
        tick();
        checks++; if (FINISHED !== 1'b1 || TIMED_OUT !== 1'b1) begin errors++; $display("FAIL timeout_fire got %b/%b exp 1/1", FINISHED, TIMED_OUT); end
        checks++; if (PKT_CNT !== 16'd0) begin errors++; $display("FAIL timeout_pkt_cnt got %0d exp 0", PKT_CNT); end
        EN = 1'b0;
        tick();
        checks++; if (TIMED_OUT !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL timeout_sticky got %b/%b exp 1/0", TIMED_OUT, BUSY); end
        EN = 1'b1;
        tick();
        checks++; if (TIMED_OUT !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", TIMED_OUT); end
        tick();
        repeat (10) tick();
        DONE_I = 1'b1; DATA_I = 32'd42;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (TIMED_OUT !== 1'b0 || PKT_CNT !== 16'd1 || FINISHED !== 1'b1) begin errors++; $display("FAIL timeout_race got %b/%0d/%b exp 0/1/1", TIMED_OUT, PKT_CNT, FINISHED); end
        EN = 1'b0;
        tick();
        $display("test_timeout done");
    endtask

    task automatic test_num_pkt_zero();
        NUM_PKT = 16'd0; GAP = 8'd0; TIMEOUT = 16'd0; EN = 1'b1;
        tick();
        checks++; if (FINISHED !== 1'b1 || START_O !== 2'b00) begin errors++; $display("FAIL zero_finish got %b/%b exp 1/00", FINISHED, START_O); end
        checks++; if (PKT_CNT !== 16'd0 || SUM_O !== 32'd0 || RESULT_O !== 32'd0) begin errors++; $display("FAIL zero_clear got %0d/%0d/%0d exp 0/0/0", PKT_CNT, SUM_O, RESULT_O); end
        EN = 1'b0;
        tick();
        checks++; if (FINISHED !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL zero_after got %b/%b exp 0/0", FINISHED, BUSY); end
        $display("test_num_pkt_zero done");
    endtask

    task automatic test_abort();
        NUM_PKT = 16'd3; GAP = 8'd0; TIMEOUT = 16'd0; EN = 1'b1;
        tick(); tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'd11;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        tick(); tick();
        EN = 1'b0;
        tick();
        checks++; if (BUSY !== 1'b0 || FINISHED !== 1'b0) begin errors++; $display("FAIL abort_idle got %b/%b exp 0/0", BUSY, FINISHED); end
        checks++; if (PKT_CNT !== 16'd1 || SUM_O !== 32'd11 || RESULT_O !== 32'd11) begin errors++; $display("FAIL abort_hold got %0d/%0d/%0d exp 1/11/11", PKT_CNT, SUM_O, RESULT_O); end
        tick();
        checks++; if (BUSY !== 1'b0 || FINISHED !== 1'b0) begin errors++; $display("FAIL abort_stay got %b/%b exp 0/0", BUSY, FINISHED); end
        NUM_PKT = 16'd1; EN = 1'b1;
        tick();
        checks++; if (PKT_CNT !== 16'd0 || SUM_O !== 32'd0 || RESULT_O !== 32'd0 || START_O !== 2'b01) begin errors++; $display("FAIL abort_restart got %0d/%0d/%0d/%b exp 0/0/0/01", PKT_CNT, SUM_O, RESULT_O, START_O); end
        tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'd3;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (PKT_CNT !== 16'd1 || SUM_O !== 32'd3 || FINISHED !== 1'b1) begin errors++; $display("FAIL abort_rerun got %0d/%0d/%b exp 1/3/1", PKT_CNT, SUM_O, FINISHED); end
        EN = 1'b0;
        tick();
        $display("test_abort done");
    endtask

    task automatic test_back_to_back();
        NUM_PKT = 16'd1; GAP = 8'd0; TIMEOUT = 16'd0; EN = 1'b1;
        tick(); tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'd6;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (FINISHED !== 1'b1) begin errors++; $display("FAIL b2b_finish got %b exp 1", FINISHED); end
        tick();
        checks++; if (BUSY !== 1'b0 || FINISHED !== 1'b0 || PKT_CNT !== 16'd1) begin errors++; $display("FAIL b2b_idle got %b/%b/%0d exp 0/0/1", BUSY, FINISHED, PKT_CNT); end
        tick();
        checks++; if (BUSY !== 1'b1 || START_O !== 2'b01 || PKT_CNT !== 16'd0) begin errors++; $display("FAIL b2b_restart got %b/%b/%0d exp 1/01/0", BUSY, START_O, PKT_CNT); end
        EN = 1'b0;
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_abort got %b exp 0", BUSY); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_issue();
        NUM_PKT = 16'd2; GAP = 8'd0; TIMEOUT = 16'd0; EN = 1'b1;
        tick(); tick(); tick();
        DONE_I = 1'b1; DATA_I = 32'd8;
        tick();
        DONE_I = 1'b0; DATA_I = 32'd0;
        checks++; if (START_O !== 2'b01 || PKT_CNT !== 16'd1) begin errors++; $display("FAIL rstmid_pre got %b/%0d exp 01/1", START_O, PKT_CNT); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (START_O !== 2'b00 || BUSY !== 1'b0 || FINISHED !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got %b/%b/%b exp 00/0/0", START_O, BUSY, FINISHED); end
        checks++; if (PKT_CNT !== 16'd0 || SUM_O !== 32'd0 || RESULT_O !== 32'd0 || TIMED_OUT !== 1'b0) begin errors++; $display("FAIL rstmid_data got %0d/%0d/%0d/%b exp 0/0/0/0", PKT_CNT, SUM_O, RESULT_O, TIMED_OUT); end
        EN = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (BUSY !== 1'b0 || START_O !== 2'b00) begin errors++; $display("FAIL rstmid_after got %b/%b exp 0/00", BUSY, START_O); end
        $display("test_reset_mid_issue done");
    endtask

    initial begin
        rst_n = 1'b0; EN = 1'b0; NUM_PKT = '0; GAP = '0; TIMEOUT = '0;
        DONE_I = 1'b0; DATA_I = '0;
        test_reset();
        test_normal();
        test_gap();
        test_sum_wrap();
        test_timeout();
        test_num_pkt_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
